// File: rtl/adxl_pkg.sv
// Shared definitions for the ADXL sample path: packer FSM encoding,
// default widths/depth, and the FIFO word formatter.
package adxl_pkg;

    localparam int DATA_WIDTH_DEF = 20;
    localparam int WORD_WIDTH_DEF = 24;
    localparam int DEPTH_DEF      = 16;
    localparam int XMARK_BIT      = 0;
    localparam int FMT_MAX        = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_X = 2'd1,
        WR_Y = 2'd2,
        WR_Z = 2'd3
    } pk_state_e;

    // Left-justifies a dw-bit sample inside a ww-bit word (carried in a
    // FMT_MAX container, caller truncates) and drives the axis marker bit.
    function automatic logic [FMT_MAX-1:0] fifo_word_fmt(
        input logic [FMT_MAX-1:0] sample,
        input int                 dw,
        input int                 ww,
        input logic               mark
    );
        logic [FMT_MAX-1:0] w;
        w            = sample << (ww - dw);
        w[XMARK_BIT] = mark;
        return w;
    endfunction

endpackage

// File: rtl/axis_fifo_packer.sv
// axis_fifo_packer: captures one X/Y/Z triple per ODR strobe, latches it for
// register_files and writes it to the FIFO as three words (X, Y, Z).
// Ports: mems_clk/rst, standby, sample_vld + x/y/z_sample, fifo_sample_num,
// full, ovr_clr in; wr_en, filter_fifo_data, x/y/zdata_valid,
// x/y/zdata_in, FIFO_OVR out.
// Option: define PACKER_XMARK_EN to set bit0 of every X word.
module axis_fifo_packer
    import adxl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int CNT_WIDTH  = 7
) (
    input  logic                  mems_clk,
    input  logic                  rst,
    input  logic                  standby,
    input  logic                  sample_vld,
    input  logic [DATA_WIDTH-1:0] x_sample,
    input  logic [DATA_WIDTH-1:0] y_sample,
    input  logic [DATA_WIDTH-1:0] z_sample,
    input  logic [CNT_WIDTH-1:0]  fifo_sample_num,
    input  logic                  full,
    input  logic                  ovr_clr,
    output logic                  wr_en,
    output logic [WORD_WIDTH-1:0] filter_fifo_data,
    output logic                  xdata_valid,
    output logic                  ydata_valid,
    output logic                  zdata_valid,
    output logic [DATA_WIDTH-1:0] xdata_in,
    output logic [DATA_WIDTH-1:0] ydata_in,
    output logic [DATA_WIDTH-1:0] zdata_in,
    output logic                  FIFO_OVR
);

`ifdef PACKER_XMARK_EN
    localparam logic XMARK = 1'b1;
`else
    localparam logic XMARK = 1'b0;
`endif

    localparam logic [CNT_WIDTH:0] ROOM_LIM = (CNT_WIDTH + 1)'(DEPTH - 3);

    pk_state_e             state_q;
    logic                  wr_en_q;
    logic [WORD_WIDTH-1:0] data_q;
    logic                  vld_q;
    logic [DATA_WIDTH-1:0] xr_q, yr_q, zr_q;
    logic [DATA_WIDTH-1:0] hy_q, hz_q;
    logic                  ovr_q, ovr_d;

    logic                  accept;
    logic                  room_ok;
    logic                  start;
    logic                  ovr_set;
    logic [CNT_WIDTH:0]    occ;

    assign accept = sample_vld & ~standby;

    // In WR_Z the Z word is still in flight, so count it as occupied.
    assign occ = {1'b0, fifo_sample_num}
               + (CNT_WIDTH + 1)'(state_q == WR_Z);

    assign room_ok = ~full & (occ <= ROOM_LIM);

    assign start = accept & room_ok
                 & ((state_q == IDLE) | (state_q == WR_Z));

    // A dropped triple, or a write landing on a full FIFO, both lose data.
    assign ovr_set = (accept & ~start) | (full & (state_q != IDLE));

    always_comb begin
        ovr_d = ovr_q;
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge mems_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wr_en_q <= 1'b0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            xr_q    <= '0;
            yr_q    <= '0;
            zr_q    <= '0;
            hy_q    <= '0;
            hz_q    <= '0;
            ovr_q   <= 1'b0;
        end else begin
            vld_q <= accept;
            ovr_q <= ovr_d;
            if (accept) begin
                xr_q <= x_sample;
                yr_q <= y_sample;
                zr_q <= z_sample;
            end
            // Holding registers only load when a new triple starts, so a
            // busy-time accept cannot corrupt the triple being written.
            if (start) begin
                hy_q <= y_sample;
                hz_q <= z_sample;
            end
            unique case (state_q)
                IDLE, WR_Z: begin
                    if (start) begin
                        state_q <= WR_X;
                        wr_en_q <= 1'b1;
                        data_q  <= WORD_WIDTH'(fifo_word_fmt(
                            FMT_MAX'(x_sample), DATA_WIDTH, WORD_WIDTH, XMARK));
                    end else begin
                        state_q <= IDLE;
                        wr_en_q <= 1'b0;
                    end
                end
                WR_X: begin
                    state_q <= WR_Y;
                    wr_en_q <= 1'b1;
                    data_q  <= WORD_WIDTH'(fifo_word_fmt(
                        FMT_MAX'(hy_q), DATA_WIDTH, WORD_WIDTH, 1'b0));
                end
                WR_Y: begin
                    state_q <= WR_Z;
                    wr_en_q <= 1'b1;
                    data_q  <= WORD_WIDTH'(fifo_word_fmt(
                        FMT_MAX'(hz_q), DATA_WIDTH, WORD_WIDTH, 1'b0));
                end
            endcase
        end
    end

    assign wr_en            = wr_en_q;
    assign filter_fifo_data = data_q;
    assign xdata_valid      = vld_q;
    assign ydata_valid      = vld_q;
    assign zdata_valid      = vld_q;
    assign xdata_in         = xr_q;
    assign ydata_in         = yr_q;
    assign zdata_in         = zr_q;
    assign FIFO_OVR         = ovr_q;

endmodule

// File: tb/tb_axis_fifo_packer.sv
// Directed self-checking bench for axis_fifo_packer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axis_fifo_packer;

    logic        clk;
    logic        rst;
    logic        standby;
    logic        sample_vld;
    logic [19:0] x_sample, y_sample, z_sample;
    logic [6:0]  fifo_sample_num;
    logic        full;
    logic        ovr_clr;
    logic        wr_en;
    logic [23:0] filter_fifo_data;
    logic        xdata_valid, ydata_valid, zdata_valid;
    logic [19:0] xdata_in, ydata_in, zdata_in;
    logic        FIFO_OVR;

    int n_chk  = 0;
    int n_fail = 0;
    logic [23:0] wq[$];

`ifdef PACKER_XMARK_EN
    localparam logic [23:0] XM = 24'h000001;
`else
    localparam logic [23:0] XM = 24'h000000;
`endif

    axis_fifo_packer dut (
        .mems_clk         (clk),
        .rst              (rst),
        .standby          (standby),
        .sample_vld       (sample_vld),
        .x_sample         (x_sample),
        .y_sample         (y_sample),
        .z_sample         (z_sample),
        .fifo_sample_num  (fifo_sample_num),
        .full             (full),
        .ovr_clr          (ovr_clr),
        .wr_en            (wr_en),
        .filter_fifo_data (filter_fifo_data),
        .xdata_valid      (xdata_valid),
        .ydata_valid      (ydata_valid),
        .zdata_valid      (zdata_valid),
        .xdata_in         (xdata_in),
        .ydata_in         (ydata_in),
        .zdata_in         (zdata_in),
        .FIFO_OVR         (FIFO_OVR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO-side write log
    always @(negedge clk) begin
        if (wr_en) wq.push_back(filter_fifo_data);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse(input logic [19:0] x, input logic [19:0] y,
                         input logic [19:0] z);
        x_sample   = x;
        y_sample   = y;
        z_sample   = z;
        sample_vld = 1'b1;
        tick();
        sample_vld = 1'b0;
    endtask

    task automatic clear_ovr();
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        standby         = 1'b0;
        sample_vld      = 1'b0;
        x_sample        = '0;
        y_sample        = '0;
        z_sample        = '0;
        fifo_sample_num = '0;
        full            = 1'b0;
        ovr_clr         = 1'b0;
        tick(2);

        // reset state
        check_eq("rst_wr_en", 32'(wr_en), 0);
        check_eq("rst_data", 32'(filter_fifo_data), 0);
        check_eq("rst_valid", 32'({xdata_valid, ydata_valid, zdata_valid}), 0);
        check_eq("rst_xdata", 32'(xdata_in), 0);
        check_eq("rst_ovr", 32'(FIFO_OVR), 0);
        rst = 1'b0;
        tick();

        // basic triple into empty FIFO
        wq.delete();
        pulse(20'h12345, 20'hFFFFF, 20'h00001);
        check_eq("t1_wr_n1", 32'(wr_en), 1);
        check_eq("t1_valids", 32'({xdata_valid, ydata_valid, zdata_valid}), 3'b111);
        check_eq("t1_xdata", 32'(xdata_in), 32'h12345);
        check_eq("t1_ydata", 32'(ydata_in), 32'hFFFFF);
        check_eq("t1_zdata", 32'(zdata_in), 32'h00001);
        tick();
        check_eq("t1_valid_1cyc", 32'(xdata_valid), 0);
        tick(3);
        check_eq("t1_nwr", wq.size(), 3);
        check_eq("t1_wx", 32'(wq[0]), 32'(24'h123450 | XM));
        check_eq("t1_wy", 32'(wq[1]), 32'hFFFFF0);
        check_eq("t1_wz", 32'(wq[2]), 32'h000010);
        check_eq("t1_ovr", 32'(FIFO_OVR), 0);
        check_eq("t1_data_hold", 32'(filter_fifo_data), 32'h000010);

        // no room: 14 of 16 occupied
        wq.delete();
        fifo_sample_num = 7'd14;
        pulse(20'h0A0A0, 20'h1, 20'h2);
        check_eq("t2_xdata", 32'(xdata_in), 32'h0A0A0);
        check_eq("t2_valid", 32'(zdata_valid), 1);
        tick(4);
        check_eq("t2_nwr", wq.size(), 0);
        check_eq("t2_ovr", 32'(FIFO_OVR), 1);
        clear_ovr();
        check_eq("t2_ovr_clr", 32'(FIFO_OVR), 0);

        // set wins over clear in the same cycle
        ovr_clr = 1'b1;
        pulse(20'h0B0B0, 20'h1, 20'h2);
        ovr_clr = 1'b0;
        check_eq("t2_set_prio", 32'(FIFO_OVR), 1);
        clear_ovr();

        // boundary: exactly 3 free words accepted
        wq.delete();
        fifo_sample_num = 7'd13;
        pulse(20'h00010, 20'h00020, 20'h00030);
        tick(4);
        check_eq("t2b_nwr", wq.size(), 3);
        check_eq("t2b_ovr", 32'(FIFO_OVR), 0);

        // full flag blocks a triple
        wq.delete();
        fifo_sample_num = 7'd0;
        full = 1'b1;
        pulse(20'h00011, 20'h00022, 20'h00033);
        full = 1'b0;
        tick(4);
        check_eq("tf_nwr", wq.size(), 0);
        check_eq("tf_ovr", 32'(FIFO_OVR), 1);
        clear_ovr();

        // second strobe while busy (WR_Y)
        wq.delete();
        pulse(20'h12345, 20'hFFFFF, 20'h00001);
        tick();
        pulse(20'hABCDE, 20'h54321, 20'h80000);
        check_eq("t3_xdata", 32'(xdata_in), 32'hABCDE);
        check_eq("t3_valid", 32'(ydata_valid), 1);
        tick(4);
        check_eq("t3_nwr", wq.size(), 3);
        check_eq("t3_wx", 32'(wq[0]), 32'(24'h123450 | XM));
        check_eq("t3_wy", 32'(wq[1]), 32'hFFFFF0);
        check_eq("t3_wz", 32'(wq[2]), 32'h000010);
        check_eq("t3_ovr", 32'(FIFO_OVR), 1);
        clear_ovr();

        // strobe during WR_Z with 12 occupied -> back-to-back
        wq.delete();
        fifo_sample_num = 7'd12;
        pulse(20'h12345, 20'hFFFFF, 20'h00001);
        tick(2);
        pulse(20'hABCDE, 20'h54321, 20'h80000);
        tick(4);
        check_eq("t4_nwr", wq.size(), 6);
        check_eq("t4_w2", 32'(wq[2]), 32'h000010);
        check_eq("t4_w3", 32'(wq[3]), 32'(24'hABCDE0 | XM));
        check_eq("t4_w4", 32'(wq[4]), 32'h543210);
        check_eq("t4_w5", 32'(wq[5]), 32'h800000);
        check_eq("t4_ovr", 32'(FIFO_OVR), 0);
        fifo_sample_num = 7'd0;

        // standby ignores strobes
        wq.delete();
        standby = 1'b1;
        pulse(20'h77777, 20'h1, 20'h2);
        check_eq("t5_valid", 32'(xdata_valid), 0);
        check_eq("t5_xdata", 32'(xdata_in), 32'hABCDE);
        tick(4);
        check_eq("t5_nwr", wq.size(), 0);
        check_eq("t5_ovr", 32'(FIFO_OVR), 0);
        standby = 1'b0;

        // async reset in WR_Y
        pulse(20'h12345, 20'hFFFFF, 20'h00001);
        tick();
        #2 rst = 1'b1;
        #1;
        check_eq("t6_wr_en", 32'(wr_en), 0);
        check_eq("t6_data", 32'(filter_fifo_data), 0);
        check_eq("t6_xdata", 32'(xdata_in), 0);
        tick();
        rst = 1'b0;
        wq.delete();
        tick(2);
        check_eq("t6_nwr_after", wq.size(), 0);
        pulse(20'h00ABC, 20'h00DEF, 20'h00123);
        tick(4);
        check_eq("t6_nwr", wq.size(), 3);
        check_eq("t6_wx", 32'(wq[0]), 32'(24'h00ABC0 | XM));
        check_eq("t6_wz", 32'(wq[2]), 32'h001230);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
